// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
//
// Moves a square ball around the active area of a video frame. A two-state
// FSM (SERVE, MOVE) advances only on the per-frame pulse. In SERVE the ball
// waits at the screen centre for SERVE_FRAMES pulses. In MOVE it travels
// SPEED pixels per axis per frame and reflects off the right, top and bottom
// walls. The left edge is either a wall or the paddle line, depending on the
// build configuration.
//
// Configuration macro: BALL_PADDLE_EN
//   defined   - the left edge is tested against the paddle. A miss pulses
//               `miss`, bumps `score` and re-serves from the centre.
//   undefined - the left edge is a plain wall. paddle_y is ignored, and
//               miss/score stay 0.
//
// Ports
//   pix_clk   in   pixel clock (only clock)
//   rst_pix_n in   asynchronous active-low reset, released synchronously
//   frame     in   one-cycle pulse at the start of each frame
//   sx, sy    in   current screen position (active-area coordinates)
//   paddle_y  in   top row of the left paddle
//   ball_x    out  ball left column (registered)
//   ball_y    out  ball top row (registered)
//   ball_pix  out  (sx, sy) was inside the ball on the previous cycle
//   miss      out  one-cycle pulse when the ball passes the paddle
//   score     out  8-bit miss count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module ball_motion #(
    parameter int CORDW        = 10,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int PADDLE_H     = 48
) (
    input  logic             pix_clk,
    input  logic             rst_pix_n,
    input  logic             frame,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [CORDW-1:0] paddle_y,
    output logic [CORDW-1:0] ball_x,
    output logic [CORDW-1:0] ball_y,
    output logic             ball_pix,
    output logic             miss,
    output logic [7:0]       score
);

    // Boundary arithmetic uses one extra bit so that sums never wrap.
    localparam int EW = CORDW + 1;

    localparam logic [EW-1:0]    X_LIM   = EW'(H_RES - BALL_SIZE);
    localparam logic [EW-1:0]    Y_LIM   = EW'(V_RES - BALL_SIZE);
    localparam logic [CORDW-1:0] X_LIM_N = CORDW'(H_RES - BALL_SIZE);
    localparam logic [CORDW-1:0] Y_LIM_N = CORDW'(V_RES - BALL_SIZE);
    localparam logic [CORDW-1:0] X_CTR   = CORDW'((H_RES - BALL_SIZE) / 2);
    localparam logic [CORDW-1:0] Y_CTR   = CORDW'((V_RES - BALL_SIZE) / 2);
    localparam logic [EW-1:0]    SPD     = EW'(SPEED);
    localparam logic [CORDW-1:0] SPD_N   = CORDW'(SPEED);
    localparam logic [EW-1:0]    SIZE    = EW'(BALL_SIZE);

    localparam int SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_SERVE = 1'b0,
        ST_MOVE  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [SCW-1:0]   serve_cnt_q, serve_cnt_d;
    logic [CORDW-1:0] ball_x_q,    ball_x_d;
    logic [CORDW-1:0] ball_y_q,    ball_y_d;
    logic             dir_x_q,     dir_x_d;     // 1 = moving right
    logic             dir_y_q,     dir_y_d;     // 1 = moving down
    logic [7:0]       score_q,     score_d;
    logic             miss_q,      miss_d;
    logic             ball_pix_q,  ball_pix_d;

    logic [EW-1:0] x_ext_s;
    logic [EW-1:0] y_ext_s;
    logic [EW-1:0] sx_ext_s;
    logic [EW-1:0] sy_ext_s;
    logic [EW-1:0] x_plus_s;
    logic [EW-1:0] y_plus_s;
    logic          paddle_hit_s;
    logic          lost_s;

    assign x_ext_s  = {1'b0, ball_x_q};
    assign y_ext_s  = {1'b0, ball_y_q};
    assign sx_ext_s = {1'b0, sx};
    assign sy_ext_s = {1'b0, sy};
    assign x_plus_s = x_ext_s + SPD;
    assign y_plus_s = y_ext_s + SPD;

`ifdef BALL_PADDLE_EN
    localparam logic [EW-1:0] PAD_H = EW'(PADDLE_H);

    logic [EW-1:0] pad_ext_s;

    assign pad_ext_s = {1'b0, paddle_y};

    // Ball and paddle rows overlap: the ball bounces off the paddle.
    assign paddle_hit_s = ((y_ext_s + SIZE) > pad_ext_s) &&
                          (y_ext_s < (pad_ext_s + PAD_H));
`else
    logic paddle_unused_s;

    // Without a paddle the left edge is a wall that always reflects.
    assign paddle_unused_s = ^paddle_y;
    assign paddle_hit_s    = 1'b1;
`endif

    // Next-state logic: pixel test every cycle, and motion and the FSM on frame pulses.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        score_d     = score_q;
        miss_d      = 1'b0;
        lost_s      = 1'b0;

        ball_pix_d = (sx_ext_s >= x_ext_s) && (sx_ext_s < (x_ext_s + SIZE)) &&
                     (sy_ext_s >= y_ext_s) && (sy_ext_s < (y_ext_s + SIZE));

        if (frame) begin
            case (state_q)
                ST_SERVE: begin
                    // The ball does not move on the pulse that ends the serve.
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_MOVE;
                        serve_cnt_d = {SCW{1'b0}};
                    end else begin
                        serve_cnt_d = serve_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_MOVE: begin
                    // x axis: the right wall clamps and reflects, and the left edge is the paddle line.
                    if (dir_x_q) begin
                        if (x_plus_s >= X_LIM) begin
                            ball_x_d = X_LIM_N;
                            dir_x_d  = 1'b0;
                        end else begin
                            ball_x_d = x_plus_s[CORDW-1:0];
                        end
                    end else if (x_ext_s > SPD) begin
                        ball_x_d = ball_x_q - SPD_N;
                    end else if (paddle_hit_s) begin
                        ball_x_d = {CORDW{1'b0}};
                        dir_x_d  = 1'b1;
                    end else begin
                        lost_s = 1'b1;
                    end

                    // y axis: both edges clamp and reflect.
                    if (dir_y_q) begin
                        if (y_plus_s >= Y_LIM) begin
                            ball_y_d = Y_LIM_N;
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = y_plus_s[CORDW-1:0];
                        end
                    end else if (y_ext_s > SPD) begin
                        ball_y_d = ball_y_q - SPD_N;
                    end else begin
                        ball_y_d = {CORDW{1'b0}};
                        dir_y_d  = 1'b1;
                    end

                    // A miss overrides both axis updates and re-serves from the centre.
                    if (lost_s) begin
                        ball_x_d    = X_CTR;
                        ball_y_d    = Y_CTR;
                        dir_x_d     = 1'b1;
                        dir_y_d     = 1'b1;
                        serve_cnt_d = {SCW{1'b0}};
                        state_d     = ST_SERVE;
                        miss_d      = 1'b1;
                        score_d     = score_q + 8'd1;
                    end else begin
                        miss_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = {SCW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset to the serve position.
    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q     <= ST_SERVE;
            serve_cnt_q <= {SCW{1'b0}};
            ball_x_q    <= X_CTR;
            ball_y_q    <= Y_CTR;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            score_q     <= 8'd0;
            miss_q      <= 1'b0;
            ball_pix_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            ball_pix_q  <= ball_pix_d;
        end
    end

    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign ball_pix = ball_pix_q;
    assign miss     = miss_q;
    assign score    = score_q;

endmodule

// File: tb/tb_ball_motion.sv
// -----------------------------------------------------------------------------
// tb_ball_motion
//
// Self-checking bench for ball_motion. The main instance uses the default
// 640x480 geometry. A second, small 64x64 instance with a 2-frame serve is
// used for the square-corner case and the 256-miss score wrap. Expected
// positions come from a behavioural model through a scoreboard queue, and
// from hand-derived checkpoint and pixel tables.
// -----------------------------------------------------------------------------
module tb_ball_motion;

`ifdef BALL_PADDLE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       rst_n;
    logic       frame;
    logic [9:0] sx, sy, paddle_y;
    logic [9:0] ball_x, ball_y;
    logic       ball_pix, miss;
    logic [7:0] score;

    // Small instance
    logic       rst2_n;
    logic       frame2;
    logic [9:0] sx2, sy2, paddle2;
    logic [9:0] bx2, by2;
    logic       pix2, miss2;
    logic [7:0] score2;

    ball_motion u_dut (
        .pix_clk(clk), .rst_pix_n(rst_n), .frame(frame),
        .sx(sx), .sy(sy), .paddle_y(paddle_y),
        .ball_x(ball_x), .ball_y(ball_y), .ball_pix(ball_pix),
        .miss(miss), .score(score)
    );

    ball_motion #(.H_RES(64), .V_RES(64), .SERVE_FRAMES(2)) u_small (
        .pix_clk(clk), .rst_pix_n(rst2_n), .frame(frame2),
        .sx(sx2), .sy(sy2), .paddle_y(paddle2),
        .ball_x(bx2), .ball_y(by2), .ball_pix(pix2),
        .miss(miss2), .score(score2)
    );

    typedef struct {
        int x; int y; bit dr; bit dd; bit serve; int cnt; int score; bit miss;
    } mst_t;

    typedef struct { int n; int x; int y; } cp_t;
    typedef struct { int sx; int sy; bit pix; } pv_t;

    int   total = 0;
    int   bad   = 0;
    mst_t m1, m2;
    mst_t q1[$];
    mst_t q2[$];
    cp_t  cps[10];
    pv_t  pvs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mst_t m_init(input int h, input int v, input int b);
        mst_t s;
        s.x = (h - b) / 2; s.y = (v - b) / 2;
        s.dr = 1'b1; s.dd = 1'b1; s.serve = 1'b1; s.cnt = 0;
        s.score = 0; s.miss = 1'b0;
        return s;
    endfunction

    // Behavioural model of one frame pulse.
    function automatic mst_t mstep(input mst_t s, input int h, input int v, input int b,
                                   input int sp, input int sf, input int ph,
                                   input int py, input bit pen);
        mst_t n;
        bit   lost;
        n = s; n.miss = 1'b0; lost = 1'b0;
        if (s.serve) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == sf) begin n.serve = 1'b0; n.cnt = 0; end
        end else begin
            if (s.dr) begin
                if (s.x + sp >= h - b) begin n.x = h - b; n.dr = 1'b0; end
                else n.x = s.x + sp;
            end else if (s.x > sp) n.x = s.x - sp;
            else if (!pen || ((s.y + b > py) && (s.y < py + ph))) begin n.x = 0; n.dr = 1'b1; end
            else lost = 1'b1;
            if (s.dd) begin
                if (s.y + sp >= v - b) begin n.y = v - b; n.dd = 1'b0; end
                else n.y = s.y + sp;
            end else if (s.y > sp) n.y = s.y - sp;
            else begin n.y = 0; n.dd = 1'b1; end
            if (lost) begin
                n = m_init(h, v, b);
                n.score = (s.score + 1) % 256;
                n.miss = 1'b1;
            end
        end
        return n;
    endfunction

    // One clock on the main DUT; expected result queued at drive, checked after the edge.
    task automatic tick1(input bit f);
        mst_t e;
        @(negedge clk);
        frame = f;
        if (f) m1 = mstep(m1, 640, 480, 8, 2, 60, 48, int'(paddle_y), PEN);
        else   m1.miss = 1'b0;
        q1.push_back(m1);
        @(posedge clk); #1;
        e = q1.pop_front();
        check("main_x", int'(ball_x), e.x);
        check("main_y", int'(ball_y), e.y);
        check("main_miss", int'(miss), int'(e.miss));
        check("main_score", int'(score), e.score);
    endtask

    task automatic tick2(input bit f);
        mst_t e;
        @(negedge clk);
        frame2 = f;
        if (f) m2 = mstep(m2, 64, 64, 8, 2, 2, 48, int'(paddle2), PEN);
        else   m2.miss = 1'b0;
        q2.push_back(m2);
        @(posedge clk); #1;
        e = q2.pop_front();
        check("small_x", int'(bx2), e.x);
        check("small_y", int'(by2), e.y);
        check("small_miss", int'(miss2), int'(e.miss));
        check("small_score", int'(score2), e.score);
    endtask

    initial begin
        int ci;

        // Hand-derived checkpoints: frame count after reset -> (x, y).
        cps[0] = '{60, 316, 236};  cps[1] = '{61, 318, 238};
        cps[2] = '{217, 630, 394}; cps[3] = '{218, 632, 392};
        cps[4] = '{219, 630, 390}; cps[5] = '{414, 240, 0};
        cps[6] = '{415, 238, 2};   cps[7] = '{533, 2, 238};
        cps[8] = '{534, 0, 240};   cps[9] = '{535, 2, 242};

        pvs[0] = '{316, 236, 1'b1}; pvs[1] = '{324, 236, 1'b0};
        pvs[2] = '{315, 236, 1'b0}; pvs[3] = '{323, 243, 1'b1};
        pvs[4] = '{316, 244, 1'b0}; pvs[5] = '{320, 235, 1'b0};

        rst_n = 1'b0; frame = 1'b0; sx = 10'd0; sy = 10'd0; paddle_y = 10'd200;
        rst2_n = 1'b0; frame2 = 1'b0; sx2 = 10'd0; sy2 = 10'd0; paddle2 = 10'd200;
        m1 = m_init(640, 480, 8);
        m2 = m_init(64, 64, 8);

        repeat (2) @(posedge clk);
        #1;
        check("rst_x", int'(ball_x), 316);
        check("rst_y", int'(ball_y), 236);
        check("rst_miss", int'(miss), 0);
        check("rst_score", int'(score), 0);
        check("rst_pix", int'(ball_pix), 0);

        // Frame pulses while reset is held must not advance the serve counter.
        @(negedge clk); frame = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_x", int'(ball_x), 316);
        @(negedge clk); frame = 1'b0; rst_n = 1'b1;

        // Pixel hit test against the centred ball.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sx = 10'(pvs[i].sx); sy = 10'(pvs[i].sy);
            @(posedge clk); #1;
            check("ball_pix", int'(ball_pix), int'(pvs[i].pix));
        end
        @(negedge clk); sx = 10'd0; sy = 10'd0;

        // Main trajectory: serve, right wall, bottom, top, left edge (paddle hit or wall).
        ci = 0;
        for (int n = 1; n <= 535; n++) begin
            tick1(1'b1);
            tick1(1'b0);
            if (ci < 10 && cps[ci].n == n) begin
                check("cp_x", int'(ball_x), cps[ci].x);
                check("cp_y", int'(ball_y), cps[ci].y);
                ci++;
            end
        end

        // Reset mid-move, asserted between clock edges.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_x", int'(ball_x), 316);
        check("midrst_y", int'(ball_y), 236);
        check("midrst_miss", int'(miss), 0);
        check("midrst_score", int'(score), 0);
        check("midrst_pix", int'(ball_pix), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        m1 = m_init(640, 480, 8);

`ifdef BALL_PADDLE_EN
        // Same trajectory, but the paddle is placed away from the ball: a miss.
        paddle_y = 10'd100;
        for (int n = 1; n <= 533; n++) begin
            tick1(1'b1);
            tick1(1'b0);
        end
        tick1(1'b1);
        check("miss_pulse", int'(miss), 1);
        check("miss_x", int'(ball_x), 316);
        check("miss_y", int'(ball_y), 236);
        check("miss_score", int'(score), 1);
        tick1(1'b0);
        check("miss_one_cycle", int'(miss), 0);
`endif

        // Small instance: square geometry gives a true corner contact.
        @(negedge clk); rst2_n = 1'b1;
`ifdef BALL_PADDLE_EN
        for (int n = 1; n <= 256 * 44; n++) begin
`else
        for (int n = 1; n <= 50; n++) begin
`endif
            tick2(1'b1);
            if (n == 15) begin
                check("corner_pre_x", int'(bx2), 54);
                check("corner_pre_y", int'(by2), 54);
            end
            if (n == 16) begin
                check("corner_x", int'(bx2), 56);
                check("corner_y", int'(by2), 56);
            end
            if (n == 17) begin
                check("corner_post_x", int'(bx2), 54);
                check("corner_post_y", int'(by2), 54);
            end
`ifdef BALL_PADDLE_EN
            if (n == 44) check("first_miss_score", int'(score2), 1);
`else
            if (n == 44) begin
                check("wall_x", int'(bx2), 0);
                check("wall_y", int'(by2), 0);
            end
            if (n == 45) begin
                check("wall_post_x", int'(bx2), 2);
                check("wall_post_y", int'(by2), 2);
                check("wall_score", int'(score2), 0);
            end
`endif
        end
`ifdef BALL_PADDLE_EN
        check("score_wrap", int'(score2), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
